// File: rtl/reg_file_mp.sv
// Multi-port register file with same-cycle write bypass and a pending-write scoreboard.
// Define REG_FILE_MP_ZERO_REG_EN to hardwire register 0 to zero.
module reg_file_mp #(
  parameter int NUM_REG = 5,
  parameter int BITS    = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_WR-1:0]         wen_i,
  input  logic [NUM_WR*NUM_REG-1:0] wa_i,
  input  logic [NUM_WR*BITS-1:0]    wd_i,
  input  logic [NUM_RD*NUM_REG-1:0] ra_i,
  output logic [NUM_RD*BITS-1:0]    rd_o,
  output logic [NUM_RD-1:0]         busy_o,
  input  logic                      pend_set_i,
  input  logic [NUM_REG-1:0]        pend_sa_i
);

  localparam int DEPTH = 1 << NUM_REG;

`ifdef REG_FILE_MP_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [BITS-1:0]    mem [DEPTH];
  logic [DEPTH-1:0]   pend;
  logic [DEPTH-1:0]   pend_nxt;

  logic [NUM_REG-1:0] wa [NUM_WR];
  logic [BITS-1:0]    wd [NUM_WR];
  logic [NUM_REG-1:0] ra [NUM_RD];
  logic [NUM_WR-1:0]  wen_eff;
  logic               pend_set_eff;

  logic [BITS-1:0]    rd_val   [NUM_RD];
  logic               rd_hit   [NUM_RD];
  logic               busy_val [NUM_RD];

  // Writes to a hardwired register 0 are dropped here so neither storage nor bypass sees them.
  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
    assign wa[k]      = wa_i[k*NUM_REG +: NUM_REG];
    assign wd[k]      = wd_i[k*BITS +: BITS];
    assign wen_eff[k] = wen_i[k] && !(ZERO_REG && (wa[k] == '0));
  end

  assign pend_set_eff = pend_set_i && !(ZERO_REG && (pend_sa_i == '0));

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    assign ra[j]                 = ra_i[j*NUM_REG +: NUM_REG];
    assign rd_o[j*BITS +: BITS]  = rd_val[j];
    assign busy_o[j]             = busy_val[j];
  end

  // Set is applied after the clears so a newly issued producer wins over a retiring one.
  always_comb begin
    pend_nxt = pend;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wen_eff[k]) pend_nxt[wa[k]] = 1'b0;
    end
    if (pend_set_eff) pend_nxt[pend_sa_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wen_eff[k]) mem[wa[k]] <= wd[k];
      end
      pend <= pend_nxt;
    end
  end

  // Ascending port scan: the highest-numbered matching writer is the one left in rd_val.
  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      rd_val[j]   = mem[ra[j]];
      rd_hit[j]   = 1'b0;
      busy_val[j] = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wen_eff[k] && (wa[k] == ra[j])) begin
          rd_val[j] = wd[k];
          rd_hit[j] = 1'b1;
        end
      end
      if (reset || (ZERO_REG && (ra[j] == '0))) begin
        rd_val[j]   = '0;
        busy_val[j] = 1'b0;
      end else begin
        busy_val[j] = pend[ra[j]] && !rd_hit[j];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int NREGS = 1 << AW;

`ifdef REG_FILE_MP_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic [NWR-1:0]     wen;
  logic [NWR*AW-1:0]  wa;
  logic [NWR*DW-1:0]  wd;
  logic [NRD*AW-1:0]  ra;
  logic [NRD*DW-1:0]  rd_o;
  logic [NRD-1:0]     busy_o;
  logic               pend_set;
  logic [AW-1:0]      pend_sa;

  logic [DW-1:0]      m_mem [NREGS];
  logic [NREGS-1:0]   m_pend;

  int vectors;
  int miscompares;

  reg_file_mp #(.NUM_REG(AW), .BITS(DW), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk        (clk),
    .reset      (reset),
    .wen_i      (wen),
    .wa_i       (wa),
    .wd_i       (wd),
    .ra_i       (ra),
    .rd_o       (rd_o),
    .busy_o     (busy_o),
    .pend_set_i (pend_set),
    .pend_sa_i  (pend_sa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset    = 1'b0;
    wen      = '0;
    wa       = '0;
    wd       = '0;
    ra       = '0;
    pend_set = 1'b0;
    pend_sa  = '0;
  endtask

  task automatic set_wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[k]         = 1'b1;
    wa[k*AW +: AW] = a;
    wd[k*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rd(input int j);
    return rd_o[j*DW +: DW];
  endfunction

  // Expected outputs from the model state and current inputs.
  task automatic settle();
    logic [AW-1:0] a;
    logic [DW-1:0] exp_rd;
    logic          exp_busy;
    logic          found;
    #3;
    for (int j = 0; j < NRD; j++) begin
      a        = ra[j*AW +: AW];
      exp_rd   = '0;
      exp_busy = 1'b0;
      if (!reset && !(ZERO && a == 0)) begin
        exp_rd   = m_mem[a];
        exp_busy = m_pend[a];
        found    = 1'b0;
        for (int k = NWR - 1; k >= 0; k--) begin
          if (!found && wen[k] && wa[k*AW +: AW] == a) begin
            exp_rd   = wd[k*DW +: DW];
            exp_busy = 1'b0;
            found    = 1'b1;
          end
        end
      end
      check($sformatf("rd%0d", j), rd(j), exp_rd);
      check($sformatf("busy%0d", j), {31'b0, busy_o[j]}, {31'b0, exp_busy});
    end
  endtask

  task automatic tick();
    logic [AW-1:0] a;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
      m_pend = '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        a = wa[k*AW +: AW];
        if (wen[k]) begin
          if (!(ZERO && a == 0)) m_mem[a] = wd[k*DW +: DW];
          m_pend[a] = 1'b0;
        end
      end
      if (pend_set && !(ZERO && pend_sa == 0)) m_pend[pend_sa] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    m_pend = '0;

    // Reset with writes and a pend_set that must be ignored
    idle();
    reset = 1'b1;
    set_wr(0, 5'd5, 32'h123);
    pend_set = 1'b1;
    pend_sa  = 5'd4;
    ra = {5'd4, 5'd5, 5'd5, 5'd5};
    settle();
    tick();

    idle();
    ra = {5'd3, 5'd2, 5'd1, 5'd0};
    settle();
    for (int j = 0; j < NRD; j++) begin
      check("post_reset_rd", rd(j), 32'h0);
      check("post_reset_busy", {31'b0, busy_o[j]}, 32'h0);
    end
    tick();

    // Write then hold
    idle();
    set_wr(0, 5'd5, 32'hDEADBEEF);
    settle();
    tick();
    for (int c = 0; c < 10; c++) begin
      idle();
      ra[0 +: AW] = 5'd5;
      settle();
      check("hold5", rd(0), 32'hDEADBEEF);
      tick();
    end

    // Same-cycle bypass
    idle();
    set_wr(0, 5'd7, 32'h1);
    settle();
    tick();
    idle();
    set_wr(0, 5'd7, 32'h22);
    ra = {5'd0, 5'd0, 5'd7, 5'd7};
    settle();
    check("bypass_rd0", rd(0), 32'h22);
    check("bypass_rd1", rd(1), 32'h22);
    tick();
    idle();
    ra[0 +: AW] = 5'd7;
    settle();
    check("after_bypass", rd(0), 32'h22);
    tick();

    // Dual-write conflict
    idle();
    set_wr(0, 5'd9, 32'hA);
    set_wr(1, 5'd9, 32'hB);
    ra[0 +: AW] = 5'd9;
    settle();
    check("conflict_bypass", rd(0), 32'hB);
    tick();
    idle();
    ra[0 +: AW] = 5'd9;
    settle();
    check("conflict_read", rd(0), 32'hB);
    tick();

    // Scoreboard
    idle();
    pend_set = 1'b1;
    pend_sa  = 5'd3;
    ra[0 +: AW] = 5'd3;
    settle();
    check("pend_same_cycle", {31'b0, busy_o[0]}, 32'h0);
    tick();
    idle();
    ra[0 +: AW] = 5'd3;
    settle();
    check("pend_set", {31'b0, busy_o[0]}, 32'h1);
    tick();
    idle();
    set_wr(0, 5'd3, 32'h33);
    pend_set = 1'b1;
    pend_sa  = 5'd3;
    ra[0 +: AW] = 5'd3;
    settle();
    check("wb_and_set_now", {31'b0, busy_o[0]}, 32'h0);
    tick();
    idle();
    ra[0 +: AW] = 5'd3;
    settle();
    check("wb_and_set_next", {31'b0, busy_o[0]}, 32'h1);
    tick();
    idle();
    set_wr(1, 5'd3, 32'h34);
    ra[0 +: AW] = 5'd3;
    settle();
    check("wb_alone_now", {31'b0, busy_o[0]}, 32'h0);
    tick();
    idle();
    ra[0 +: AW] = 5'd3;
    settle();
    check("wb_alone_next", {31'b0, busy_o[0]}, 32'h0);
    check("wb_alone_data", rd(0), 32'h34);
    tick();

    // Register 0
    idle();
    set_wr(0, 5'd0, 32'hFFFF);
    settle();
    check("zero_bypass", rd(0), ZERO ? 32'h0 : 32'hFFFF);
    tick();
    idle();
    pend_set = 1'b1;
    pend_sa  = 5'd0;
    settle();
    check("zero_read", rd(0), ZERO ? 32'h0 : 32'hFFFF);
    tick();
    idle();
    settle();
    check("zero_busy", {31'b0, busy_o[0]}, ZERO ? 32'h0 : 32'h1);
    tick();

    // Random traffic on a narrow address window to provoke conflicts and hazards
    for (int c = 0; c < 600; c++) begin
      idle();
      reset = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < NWR; k++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(k, 5'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7)), $urandom);
      end
      for (int j = 0; j < NRD; j++)
        ra[j*AW +: AW] = 5'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 31 : 7));
      pend_set = ($urandom_range(0, 2) == 0);
      pend_sa  = 5'($urandom_range(0, 7));
      settle();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Multi-port register file for the pipeline decode/writeback stages.
- Generalised in address width, data width, read-port count and write-port count.
- Keeps same-cycle write-to-read bypass; adds synchronous clear and a per-register pending-write scoreboard for hazard detection.
- Decode reads operands and busy flags; issue marks destinations pending; writeback writes data and clears pending.

Parameters:
- NUM_REG, 5: address width in bits; the file holds 2**NUM_REG registers.
- BITS, 32: data width.
- NUM_RD, 2: number of read ports (1..4).
- NUM_WR, 1: number of write ports (1..2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- wen_i  input  NUM_WR  per-port write enable.
- wa_i  input  NUM_WR*NUM_REG  write addresses; port k is at bits [k*NUM_REG +: NUM_REG].
- wd_i  input  NUM_WR*BITS  write data; port k is at bits [k*BITS +: BITS].
- ra_i  input  NUM_RD*NUM_REG  read addresses, packed the same way.
- rd_o  output  NUM_RD*BITS  read data, packed the same way.
- busy_o  output  NUM_RD  pending flag of the register addressed by each read port.
- pend_set_i  input  1  mark register pend_sa_i pending (instruction issued with this destination).
- pend_sa_i  input  NUM_REG  register to mark pending.

Behaviour:
- Storage: 2**NUM_REG x BITS array plus a 2**NUM_REG-bit pending vector.
- Reset (reset=1 at a rising edge):
  - Every register becomes 0 and every pending bit is cleared.
  - Writes and pend_set_i are ignored in that cycle.
  - While reset is high, rd_o is forced to all zeros and busy_o to all zeros.
- Write: on each rising edge with reset=0, each port k with wen_i[k]=1 writes wd_i[k] to register wa_i[k].
- Write conflict: two write ports enabled to the same address -> the higher-numbered port wins, for both storage and bypass.
- Read: combinational, zero latency. rd_o[j] equals the register at ra_i[j], except:
  - Bypass: if any enabled write port targets ra_i[j] this cycle, rd_o[j] is that port's wd_i (winning port per the conflict rule), giving the new value in the same cycle.
- Pending scoreboard, updated on each rising edge with reset=0:
  - Clear: every enabled write port clears the pending bit of its wa_i.
  - Set: pend_set_i=1 sets the pending bit of pend_sa_i.
  - Set and clear on the same register in the same cycle -> the bit ends set (the newer producer wins).
- busy_o[j]:
  - equals pending[ra_i[j]] AND NOT (some enabled write port targets ra_i[j] this cycle).
  - A same-cycle writeback therefore resolves the hazard combinationally.
  - pend_set_i does not affect busy_o until the next cycle.
- Untouched registers hold their values indefinitely.
- Every output is a pure function of current state and inputs; no registered outputs.

Optional Feature:
- Macro: REG_FILE_MP_ZERO_REG_EN.
- When defined, register 0 is hardwired:
  - reads of address 0 return 0 regardless of writes or bypass;
  - writes to address 0 are discarded;
  - pending bit 0 is never set, so busy_o is 0 for address 0.
- When not defined, register 0 is an ordinary register with no special handling.

Test Plan:
- Reset then read: assert reset 1 cycle, release, set ra_i to 0..3 -> rd_o all 0, busy_o all 0.
- Write then read: wen_i[0]=1, wa=5, wd=32'hDEADBEEF for 1 cycle, then ra0=5 -> rd0=32'hDEADBEEF, held across 10 idle cycles.
- Same-cycle bypass: reg 7 holds 32'h1; in one cycle wen=1, wa=7, wd=32'h22, ra0=ra1=7 -> rd0=rd1=32'h22 that cycle, and 32'h22 the next cycle.
- Dual-write conflict (NUM_WR=2): port0 writes 9 <- 32'hA while port1 writes 9 <- 32'hB -> bypass and later read return 32'hB.
- Scoreboard:
  - pend_set_i=1, pend_sa=3 -> next cycle busy for ra=3 is 1;
  - writeback to 3 in the same cycle as a new pend_set to 3 -> busy_o is 0 in that cycle and 1 in the next;
  - a later writeback alone -> busy_o returns to 0.
- Zero register with REG_FILE_MP_ZERO_REG_EN defined: write 32'hFFFF to address 0 with ra0=0 -> rd0=0 in that cycle and after; pend_set to 0 -> busy stays 0. Without the macro: address 0 reads back 32'hFFFF.
